// File: rtl/wb_regfile.sv
// wb_regfile: Wishbone pipelined-mode register file with ID, status,
// free-running counter, pulse-strobe and read/write slots.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   wb_cyc_i .. wb_dat_i  Wishbone request (pipelined mode)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o,
//   wb_stall_o            Wishbone response, one cycle after acceptance
//   stat_i                board status, sampled every cycle into slot 1
//   pulse_o               one-cycle command strobes from writes to slot 3
//   regs_o                flattened register contents, slot k at [32k+31:32k]
module wb_regfile #(
   parameter int unsigned NREGS    = 16,
   parameter logic [31:0] BOARD_ID = 32'h57464431
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_rty_o,
   output logic                  wb_stall_o,
   input  logic [31:0]           stat_i,
   output logic [31:0]           pulse_o,
   output logic [NREGS*32-1:0]   regs_o
);

   logic        stall_q;
   logic        ack_q;
   logic        err_q;
   logic [31:0] rdat_q;
   logic [31:0] cnt_q;
   logic [31:0] stat_q;
   logic [31:0] pulse_q;
   logic [31:0] rw_q [4:NREGS-1];

   logic        accept;
   logic        in_range;
   logic        wr;
   logic        rd;
   logic        hit_id;
   logic        hit_stat;
   logic        hit_cnt;
   logic        hit_pls;
   logic        cnt_clr;
   logic [31:0] mask;
   logic [31:0] cnt_nxt;
   logic [31:0] rw_rd;
   logic [31:0] rd_data;

   assign accept   = wb_cyc_i & wb_stb_i & ~stall_q;
   assign in_range = wb_adr_i < 32'(NREGS);
   assign wr       = accept & in_range & wb_we_i;
   assign rd       = accept & in_range & ~wb_we_i;

   assign hit_id   = wb_adr_i == 32'd0;
   assign hit_stat = wb_adr_i == 32'd1;
   assign hit_cnt  = wb_adr_i == 32'd2;
   assign hit_pls  = wb_adr_i == 32'd3;

   assign mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                  {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

   // Clear beats increment; a read of the counter returns the value
   // the counter takes on the acceptance edge.
   assign cnt_clr = wr & hit_cnt & (|wb_sel_i);
   assign cnt_nxt = cnt_clr ? 32'd0 : cnt_q + 32'd1;

   always_comb begin
      rw_rd = '0;
      for (int k = 4; k < int'(NREGS); k++) begin
         if (wb_adr_i == 32'(k)) rw_rd = rw_q[k];
      end
   end

   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         hit_id:   rd_data = BOARD_ID;
         hit_stat: rd_data = stat_i;
         hit_cnt:  rd_data = cnt_nxt;
         hit_pls:  rd_data = '0;
         default:  rd_data = rw_rd;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stall_q <= 1'b1;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
         cnt_q   <= '0;
         stat_q  <= '0;
         pulse_q <= '0;
         for (int k = 4; k < int'(NREGS); k++) rw_q[k] <= '0;
      end else begin
         stall_q <= 1'b0;
         stat_q  <= stat_i;
         cnt_q   <= cnt_nxt;
         ack_q   <= accept & in_range;
         err_q   <= accept & ~in_range;
         rdat_q  <= rd ? rd_data : 32'd0;
         pulse_q <= (wr & hit_pls) ? (wb_dat_i & mask) : 32'd0;
         for (int k = 4; k < int'(NREGS); k++) begin
            if (wr && wb_adr_i == 32'(k))
               rw_q[k] <= (rw_q[k] & ~mask) | (wb_dat_i & mask);
         end
      end
   end

   // Dropping cyc in the response cycle hides the response only;
   // state changes from the accepted request stay in place.
   assign wb_ack_o   = ack_q & wb_cyc_i;
   assign wb_err_o   = err_q & wb_cyc_i;
   assign wb_dat_o   = wb_ack_o ? rdat_q : 32'd0;
   assign wb_rty_o   = 1'b0;
   assign wb_stall_o = stall_q;
   assign pulse_o    = pulse_q;

   assign regs_o[31:0]   = BOARD_ID;
   assign regs_o[63:32]  = stat_q;
   assign regs_o[95:64]  = cnt_q;
   assign regs_o[127:96] = 32'd0;

   for (genvar g = 4; g < int'(NREGS); g++) begin : g_slot
      assign regs_o[32*g +: 32] = rw_q[g];
   end

endmodule
